// File: rtl/compressor_result_serializer_pkg.sv
// Shared definitions for the compressor result serializer.
// - state_t      : frame FSM states (idle / shifting data bits / parity beat)
// - even_parity  : parity bit that makes the XOR of data plus parity equal 0
// - FRAME_LEN    : beats per frame for the default 28-bit (mul14) result
package compressor_result_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PAR
  } state_t;

  localparam int unsigned NCOL_DEF  = 28;
  localparam int unsigned FRAME_LEN = NCOL_DEF + 1;

  // Widest result word the parity helper accepts; narrower words are zero-extended.
  localparam int unsigned PAR_MAX_W = 64;

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/compressor_result_serializer_shift.sv
// Datapath of the serializer: shadow register, bit index and the registered
// sout/valid/last output stage.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   load_i            capture dst_i/par_i and present bit 0 next cycle
//   dst_i, par_i      result word and its precomputed even parity
//   shift_i           current data beat accepted, present the next data bit
//   to_par_i          final data beat accepted, present the parity bit
//   drain_i           parity beat accepted, drop valid
//   last_data_o       the bit on sout_o is data bit NCOL-1
//   sout_o, sout_valid_o, sout_last_o  registered serial output stage
module serializer_shift_core #(
  parameter int unsigned NCOL  = 28,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [NCOL-1:0] dst_i,
  input  logic            par_i,
  input  logic            shift_i,
  input  logic            to_par_i,
  input  logic            drain_i,
  output logic            last_data_o,
  output logic            sout_o,
  output logic            sout_valid_o,
  output logic            sout_last_o
);

  // Bit 0 goes straight to the output register on capture, so the shadow only
  // needs to hold the remaining NCOL-1 bits.
  logic [NCOL-2:0]  shadow_q, shadow_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             par_q, par_d;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;

  always_comb begin
    shadow_d = shadow_q;
    idx_d    = idx_q;
    par_d    = par_q;
    sout_d   = sout_q;
    valid_d  = valid_q;
    last_d   = last_q;
    if (load_i) begin
      shadow_d = dst_i[NCOL-1:1];
      idx_d    = '0;
      par_d    = par_i;
      sout_d   = dst_i[0];
      valid_d  = 1'b1;
      last_d   = 1'b0;
    end else if (shift_i) begin
      shadow_d = shadow_q >> 1;
      idx_d    = idx_q + 1'b1;
      sout_d   = shadow_q[0];
    end else if (to_par_i) begin
      sout_d   = par_q;
      last_d   = 1'b1;
    end else if (drain_i) begin
      sout_d   = 1'b0;
      valid_d  = 1'b0;
      last_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      idx_q    <= '0;
      par_q    <= 1'b0;
      sout_q   <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      par_q    <= par_d;
      sout_q   <= sout_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  assign last_data_o  = (idx_q == CNT_W'(NCOL - 1));
  assign sout_o       = sout_q;
  assign sout_valid_o = valid_q;
  assign sout_last_o  = last_q;

endmodule

// File: rtl/compressor_result_serializer.sv
// Captures the compressor's parallel sum word and shifts it out LSB first,
// followed by an even-parity beat, over a valid/ready serial interface.
// Ports:
//   clk, rst             clock, async active-high reset
//   dst                  compressor result (bit i = dst<i>)
//   cap_valid/cap_ready  capture handshake; ready only while idle
//   sout, sout_valid     serial bit and its valid
//   sout_last            the current bit is the parity (final) beat
//   sout_ready           downstream accepts the current bit
//   overrun              sticky: capture requested while busy; clr_ovr clears
//   frame_cnt            completed frames, wraps silently
module compressor_result_serializer
  import compressor_result_serializer_pkg::*;
#(
  parameter int unsigned NCOL   = 28,
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCOL-1:0]   dst,
  input  logic              cap_valid,
  output logic              cap_ready,
  output logic              sout,
  output logic              sout_valid,
  output logic              sout_last,
  input  logic              sout_ready,
  output logic              overrun,
  input  logic              clr_ovr,
  output logic [FCNT_W-1:0] frame_cnt
);

  state_t state_q, state_d;

  logic              overrun_q, overrun_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic accept;
  logic last_data;
  logic load, shift, to_par, drain;

  assign accept = sout_valid & sout_ready;

  serializer_shift_core #(
    .NCOL  (NCOL),
    .CNT_W (CNT_W)
  ) u_core (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_i       (load),
    .dst_i        (dst),
    .par_i        (even_parity(PAR_MAX_W'(dst))),
    .shift_i      (shift),
    .to_par_i     (to_par),
    .drain_i      (drain),
    .last_data_o  (last_data),
    .sout_o       (sout),
    .sout_valid_o (sout_valid),
    .sout_last_o  (sout_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cap_valid)            state_d = SHIFT;
      SHIFT:   if (accept && last_data)  state_d = PAR;
      PAR:     if (accept)               state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  always_comb begin
    cap_ready = (state_q == IDLE);
    load      = (state_q == IDLE)  && cap_valid;
    shift     = (state_q == SHIFT) && accept && !last_data;
    to_par    = (state_q == SHIFT) && accept &&  last_data;
    drain     = (state_q == PAR)   && accept;
  end

  // A set event in the same cycle as clr_ovr wins.
  always_comb begin
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;
    if (cap_valid && !cap_ready) overrun_d = 1'b1;
    else if (clr_ovr)            overrun_d = 1'b0;
    if (drain)                   frame_cnt_d = frame_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_compressor_result_serializer.sv
module tb_compressor_result_serializer;
  import compressor_result_serializer_pkg::*;

  localparam int NCOL    = 28;
  localparam int CNT_W   = 5;
  localparam int FCNT_W  = 16;
  localparam int SFCNT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCOL-1:0]   dst;
  logic              cap_valid;
  logic              cap_ready;
  logic              sout, sout_valid, sout_last;
  logic              sout_ready = 1'b1;
  logic              overrun;
  logic              clr_ovr;
  logic [FCNT_W-1:0] frame_cnt;

  // narrow-counter build sharing the same stimulus, used for the wrap check
  logic               cap_ready_w, sout_w, sout_valid_w, sout_last_w, overrun_w;
  logic [SFCNT_W-1:0] frame_cnt_w;

  always #5 clk = ~clk;

  compressor_result_serializer #(.NCOL(NCOL), .CNT_W(CNT_W), .FCNT_W(FCNT_W)) dut (
    .clk(clk), .rst(rst), .dst(dst), .cap_valid(cap_valid), .cap_ready(cap_ready),
    .sout(sout), .sout_valid(sout_valid), .sout_last(sout_last), .sout_ready(sout_ready),
    .overrun(overrun), .clr_ovr(clr_ovr), .frame_cnt(frame_cnt)
  );

  compressor_result_serializer #(.NCOL(NCOL), .CNT_W(CNT_W), .FCNT_W(SFCNT_W)) dut_w (
    .clk(clk), .rst(rst), .dst(dst), .cap_valid(cap_valid), .cap_ready(cap_ready_w),
    .sout(sout_w), .sout_valid(sout_valid_w), .sout_last(sout_last_w), .sout_ready(sout_ready),
    .overrun(overrun_w), .clr_ovr(clr_ovr), .frame_cnt(frame_cnt_w)
  );

  typedef struct {
    logic data;
    logic last;
  } beat_t;

  beat_t           exp_q[$];
  logic [NCOL-1:0] word_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  int              beats = 0;
  int              frames_model = 0;
  logic            pend = 1'b0;
  logic            prev_stall = 1'b0;
  logic [2:0]      prev_out = '0;
  logic [NCOL-1:0] asm_word = '0;
  logic            rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: data bits LSB first, then the bit that makes the total bit count of ones even.
  task automatic push_frame(input logic [NCOL-1:0] d);
    beat_t b;
    for (int unsigned i = 0; i < NCOL; i++) begin
      b.data = d[i];
      b.last = 1'b0;
      exp_q.push_back(b);
    end
    b.data = ($countones(d) % 2 == 1) ? 1'b1 : 1'b0;
    b.last = 1'b1;
    exp_q.push_back(b);
    word_q.push_back(d);
  endtask

  // Monitor / scoreboard, sampling on the falling edge.
  always @(negedge clk) begin
    beat_t e;
    logic [NCOL-1:0] w;
    if (rst) begin
      beats        = 0;
      frames_model = 0;
      pend         = 1'b0;
      prev_stall   = 1'b0;
    end else begin
      if (pend) begin
        check("frame_cnt", 64'(frame_cnt), 64'(frames_model % (1 << FCNT_W)));
        check("frame_cnt_w4", 64'(frame_cnt_w), 64'(frames_model % (1 << SFCNT_W)));
        pend = 1'b0;
      end
      if (prev_stall)
        check("stall_hold", 64'({sout, sout_valid, sout_last}), 64'(prev_out));
      if (sout_valid && sout_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got sout=%0b last=%0b with empty queue at %0t",
                   sout, sout_last, $time);
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'({sout, sout_last}), 64'({e.data, e.last}));
          if (!e.last) begin
            if (beats < NCOL) asm_word[beats] = sout;
            beats++;
          end else begin
            check("frame_len", 64'(beats + 1), 64'(FRAME_LEN));
            w = word_q.pop_front();
            check("reassembled", 64'(asm_word), 64'(w));
            frames_model++;
            pend  = 1'b1;
            beats = 0;
          end
        end
      end
      prev_stall = sout_valid && !sout_ready;
      prev_out   = {sout, sout_valid, sout_last};
    end
  end

  // Downstream ready: always high, or a random 50% duty when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      sout_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // All stimulus tasks enter and leave at posedge+1.
  task automatic send_frame(input logic [NCOL-1:0] d);
    int unsigned k;
    for (k = 0; k < 2000; k++) begin
      if (cap_ready) break;
      @(posedge clk);
      #1;
    end
    if (k == 2000) check("cap_ready_timeout", 64'(cap_ready), 64'(1));
    cap_valid = 1'b1;
    dst       = d;
    push_frame(d);
    @(posedge clk);
    #1;
    cap_valid = 1'b0;
    dst       = NCOL'($urandom);
    check("latency_valid", 64'(sout_valid), 64'(1));
    check("busy_cap_ready", 64'(cap_ready), 64'(0));
  endtask

  task automatic wait_drain();
    int unsigned k;
    for (k = 0; k < 4000; k++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && cap_ready) break;
    end
    if (k == 4000) check("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    rst       = 1'b1;
    cap_valid = 1'b0;
    clr_ovr   = 1'b0;
    dst       = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_cap_ready", 64'(cap_ready), 64'(1));
    check("rst_sout", 64'(sout), 64'(0));
    check("rst_sout_valid", 64'(sout_valid), 64'(0));
    check("rst_sout_last", 64'(sout_last), 64'(0));
    check("rst_overrun", 64'(overrun), 64'(0));
    check("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    @(posedge clk);
    #1;

    // Single set bit, then a two-bit word with even parity.
    send_frame(28'h0000001);
    wait_drain();
    check("no_overrun_idle", 64'(overrun), 64'(0));
    send_frame(28'h0000003);
    wait_drain();

    // Random backpressure.
    rand_rdy = 1'b1;
    send_frame(28'hA5A5A5A);
    wait_drain();
    rand_rdy = 1'b0;

    // Overrun set / clear / set-wins-over-clear while busy.
    send_frame(NCOL'($urandom));
    repeat (2) begin @(posedge clk); #1; end
    cap_valid = 1'b1;
    dst       = NCOL'($urandom);
    @(posedge clk); #1;
    cap_valid = 1'b0;
    check("overrun_set", 64'(overrun), 64'(1));
    clr_ovr = 1'b1;
    @(posedge clk); #1;
    clr_ovr = 1'b0;
    check("overrun_clr", 64'(overrun), 64'(0));
    cap_valid = 1'b1;
    clr_ovr   = 1'b1;
    @(posedge clk); #1;
    cap_valid = 1'b0;
    clr_ovr   = 1'b0;
    check("overrun_set_wins", 64'(overrun), 64'(1));
    check("still_busy", 64'(cap_ready), 64'(0));
    clr_ovr = 1'b1;
    @(posedge clk); #1;
    clr_ovr = 1'b0;
    check("overrun_clr2", 64'(overrun), 64'(0));
    wait_drain();

    // Back-to-back frames with random data.
    for (int i = 0; i < 3; i++) send_frame(NCOL'($urandom));
    wait_drain();

    // Reset in the middle of a frame.
    send_frame(NCOL'($urandom));
    for (k = 0; k < 200; k++) begin
      if (beats >= 10) break;
      @(posedge clk);
      #1;
    end
    if (k == 200) check("beat10_timeout", 64'(beats), 64'(10));
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(sout_valid), 64'(0));
    check("async_rst_frame_cnt", 64'(frame_cnt), 64'(0));
    exp_q.delete();
    word_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_cap_ready", 64'(cap_ready), 64'(1));
    check("post_rst_frame_cnt", 64'(frame_cnt), 64'(0));
    check("post_rst_valid", 64'(sout_valid), 64'(0));

    // 16 frames: the 4-bit counter build wraps to 0.
    for (int i = 0; i < 16; i++) begin
      rand_rdy = (i % 2 == 1);
      send_frame(NCOL'($urandom));
      wait_drain();
    end
    rand_rdy = 1'b0;
    check("wrap_main", 64'(frame_cnt), 64'(16));
    check("wrap_w4", 64'(frame_cnt_w), 64'(0));
    send_frame(NCOL'($urandom));
    wait_drain();
    @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
